// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 stream multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Next channel index after idx, wrapping back to 0 at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotate a doubled request vector so the search starts
// just after the last grant, then priority-encode the lowest set bit.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  req,
  input  logic            advance,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [2*NCH-1:0] req_dbl;
  logic [NCH-1:0]   req_rot;
  int unsigned      start;
  int unsigned      offset;
  int unsigned      idx;

  always_comb begin
    start   = wrap_inc(32'(ptr_q), NCH);
    req_dbl = {req, req};
    req_rot = req_dbl[start +: NCH];
    offset  = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = i;
    end
    idx = start + offset;
    if (idx >= NCH) idx = idx - NCH;
    grant       = SELW'(idx);
    grant_valid = |req;
    ptr_d       = (advance && grant_valid) ? grant : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= SELW'(NCH - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_n_1_arb.sv
// N-to-1 valid/ready stream mux with fixed-select or round-robin arbitration
// feeding a single-entry registered output stage.
module mux_n_1_arb
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  logic             rel_q;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;

  logic [SELW-1:0]  rr_grant, grant;
  logic             rr_gv, fx_gv, grant_valid;
  logic             load_en, xfer, rr_adv;

  rr_arbiter #(.NCH(NCH)) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (in_valid),
    .advance     (rr_adv),
    .grant       (rr_grant),
    .grant_valid (rr_gv)
  );

  always_comb begin
    fx_gv = 1'b0;
    if (32'(sel) < NCH) fx_gv = in_valid[sel];
    if (mode == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_gv;
    end else begin
      grant       = sel;
      grant_valid = fx_gv;
    end
  end

  // in_ready is held low until the reset-release flag has been registered.
  always_comb begin
    load_en  = !out_valid_q || out_ready;
    in_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      in_ready[k] = rel_q && load_en && grant_valid && (grant == SELW'(k));
    end
    xfer   = |in_ready;
    rr_adv = xfer && (mode == MODE_RR);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[32'(grant)*WIDTH +: WIDTH];
      out_ch_d    = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      rel_q       <= 1'b1;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_n_1_arb.sv
// Directed bench for mux_n_1_arb: the driver pushes hand-computed beats into a
// queue, a negedge monitor pops and compares whenever a beat is consumed.
module tb_mux_n_1_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  logic [7:0] dat [4] = '{8'h11, 8'h22, 8'hA5, 8'h3C};
  logic [9:0] exp_q [$];

  mux_n_1_arb #(.WIDTH(8), .NCH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; exp_rdy is the hand-computed in_ready for it.
  task automatic step(input string name, input logic m, input logic [1:0] s,
                      input logic [3:0] v, input logic ordy, input logic [3:0] exp_rdy);
    @(posedge clk);
    #2;
    mode = m; sel = s; in_valid = v; out_ready = ordy;
    #1;
    check(name, 32'(in_ready), 32'(exp_rdy));
    for (int k = 0; k < 4; k++) begin
      if (exp_rdy[k]) exp_q.push_back({2'(k), dat[k]});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat: got ch%0d data %0h expected none", out_ch, out_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("beat", {22'd0, out_ch, out_data}, {22'd0, e});
      end
    end
  end

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {dat[3], dat[2], dat[1], dat[0]};
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 0);

    step("fix_sel2", 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100);
    step("fix_sel2_inv", 1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000);
    step("idle", 1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000);
    check("drained_out_valid", 32'(out_valid), 0);

    for (int i = 0; i < 8; i++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (i % 4);
      step("rr_all", 1'b1, 2'd0, 4'b1111, 1'b1, oh);
    end
    step("rr_1001_a", 1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001);
    step("rr_1001_b", 1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000);
    step("rr_1001_c", 1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001);
    step("rr_1001_d", 1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000);

    step("bp_load", 1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      step("bp_hold_rdy", 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000);
      check("bp_hold_data", 32'(out_data), 32'h3C);
      check("bp_hold_valid", 32'(out_valid), 1);
    end
    step("bp_reload", 1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010);
    step("bp_drain", 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000);
    check("no_bubble_ch", 32'(out_ch), 1);
    check("no_bubble_valid", 32'(out_valid), 1);

    step("mid_load", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100);
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    in_valid  = 4'b0000;
    rst_n     = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_data", 32'(out_data), 0);
    if (exp_q.size() == 1) void'(exp_q.pop_front());
    else check("mid_rst_queue", 32'(exp_q.size()), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step("rr_restart", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001);
    step("final_drain", 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000);
    step("final_idle", 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
